// File: rtl/v_sram_mp.sv
// Behavioural 2-read / 2-write SRAM with byte enables, a collision rule, optional bypass and a clear sequencer.
// Latency: reads return RD_LAT cycles after the request edge. Writes land on the request edge.
// Backpressure: none. Requests are ignored while init_busy is high or reset is high.
//
// Ports:
//   clock, reset            : sole clock and synchronous active-high reset
//   init_busy               : high while the array is being cleared after reset
//   we/wa/wd/wbe [1,2]      : write enable, address, data and byte enables per write port
//   re/ra [1,2]             : read request and address per read port
//   rd/rvalid [1,2]         : read data, and a one-cycle valid strobe; rd holds between strobes
//   wcollide                : one-cycle pulse after both ports wrote overlapping bytes of one address
module v_sram_mp #(
    parameter int DATA_W = 192,
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9,
    parameter int RD_LAT = 1,
    parameter int BYPASS = 1,
    parameter int BE_W   = DATA_W / 8
) (
    input  logic              clock,
    input  logic              reset,
    output logic              init_busy,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    input  logic [BE_W-1:0]   wbe1,
    input  logic              we2,
    input  logic [ADDR_W-1:0] wa2,
    input  logic [DATA_W-1:0] wd2,
    input  logic [BE_W-1:0]   wbe2,
    input  logic              re1,
    input  logic [ADDR_W-1:0] ra1,
    output logic [DATA_W-1:0] rd1,
    output logic              rvalid1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd2,
    output logic              rvalid2,
    output logic              wcollide
);

    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(DEPTH - 1);

    typedef enum logic {INIT, READY} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_nxt;
    logic              w_clr_we;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_act;
    logic              w_we1_ok, w_we2_ok;
    logic              w_wa1_in, w_wa2_in, w_ra1_in, w_ra2_in;
    logic [DATA_W-1:0] w_wbase1, w_wbase2, w_rbase1, w_rbase2;
    logic [DATA_W-1:0] w_wnew1, w_wnew2;
    logic              w_rv_in [2];
    logic [DATA_W-1:0] w_rd_in [2];

    logic              r_pv [2][RD_LAT];
    logic [DATA_W-1:0] r_pd [2][RD_LAT];
    logic              r_wcollide;

    // Overlay both write ports onto a word at address a; port 2 owns any byte it enables.
    function automatic logic [DATA_W-1:0] f_merge(
        input logic [ADDR_W-1:0] a,
        input logic [DATA_W-1:0] base,
        input logic              e1,
        input logic [ADDR_W-1:0] a1,
        input logic [DATA_W-1:0] d1,
        input logic [BE_W-1:0]   b1,
        input logic              e2,
        input logic [ADDR_W-1:0] a2,
        input logic [DATA_W-1:0] d2,
        input logic [BE_W-1:0]   b2
    );
        logic [DATA_W-1:0] v;
        v = base;
        for (int b = 0; b < BE_W; b++) begin
            if (e2 && (a2 == a) && b2[b]) begin
                v[b*8 +: 8] = d2[b*8 +: 8];
            end else if (e1 && (a1 == a) && b1[b]) begin
                v[b*8 +: 8] = d1[b*8 +: 8];
            end
        end
        return v;
    endfunction

    // ---------------- clear sequencer ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= INIT;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_clr_we    = 1'b0;
        case (r_state)
            INIT: begin
                w_clr_we = 1'b1;
                if (r_ptr == LP_LAST) begin
                    w_state_nxt = READY;
                end else begin
                    w_ptr_nxt = r_ptr + ADDR_W'(1);
                end
            end
            default: begin
                w_state_nxt = READY;
            end
        endcase
    end

    assign init_busy = (r_state == INIT);

    // ---------------- request qualification and word merge ----------------
    always_comb begin
        w_act    = (r_state == READY) && !reset;
        w_wa1_in = ({1'b0, wa1} < LP_DEPTH);
        w_wa2_in = ({1'b0, wa2} < LP_DEPTH);
        w_ra1_in = ({1'b0, ra1} < LP_DEPTH);
        w_ra2_in = ({1'b0, ra2} < LP_DEPTH);
        // Out-of-range writes are dropped, so they never take part in a merge or a bypass.
        w_we1_ok = w_act && we1 && w_wa1_in;
        w_we2_ok = w_act && we2 && w_wa2_in;
        w_wbase1 = w_wa1_in ? r_mem[wa1] : '0;
        w_wbase2 = w_wa2_in ? r_mem[wa2] : '0;
        w_rbase1 = w_ra1_in ? r_mem[ra1] : '0;
        w_rbase2 = w_ra2_in ? r_mem[ra2] : '0;
        // On a same-address collision both merges yield the same word, so both writes agree.
        w_wnew1  = f_merge(wa1, w_wbase1, w_we1_ok, wa1, wd1, wbe1, w_we2_ok, wa2, wd2, wbe2);
        w_wnew2  = f_merge(wa2, w_wbase2, w_we1_ok, wa1, wd1, wbe1, w_we2_ok, wa2, wd2, wbe2);
        w_rv_in[0] = w_act && re1;
        w_rv_in[1] = w_act && re2;
        if (BYPASS != 0) begin
            w_rd_in[0] = f_merge(ra1, w_rbase1, w_we1_ok, wa1, wd1, wbe1, w_we2_ok, wa2, wd2, wbe2);
            w_rd_in[1] = f_merge(ra2, w_rbase2, w_we1_ok, wa1, wd1, wbe1, w_we2_ok, wa2, wd2, wbe2);
        end else begin
            w_rd_in[0] = w_rbase1;
            w_rd_in[1] = w_rbase2;
        end
    end

    // ---------------- array ----------------
    always_ff @(posedge clock) begin
        if (!reset && w_clr_we) begin
            r_mem[r_ptr] <= '0;
        end else begin
            if (w_we1_ok) begin
                r_mem[wa1] <= w_wnew1;
            end
            if (w_we2_ok) begin
                r_mem[wa2] <= w_wnew2;
            end
        end
    end

    // ---------------- read pipelines ----------------
    // Data stages only load behind a valid, so the last stage holds the last returned word.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int p = 0; p < 2; p++) begin
                for (int k = 0; k < RD_LAT; k++) begin
                    r_pv[p][k] <= 1'b0;
                    r_pd[p][k] <= '0;
                end
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                r_pv[p][0] <= w_rv_in[p];
                if (w_rv_in[p]) begin
                    r_pd[p][0] <= w_rd_in[p];
                end
                for (int k = 1; k < RD_LAT; k++) begin
                    r_pv[p][k] <= r_pv[p][k-1];
                    if (r_pv[p][k-1]) begin
                        r_pd[p][k] <= r_pd[p][k-1];
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wcollide <= 1'b0;
        end else begin
            r_wcollide <= w_act && we1 && we2 && (wa1 == wa2) && ((wbe1 & wbe2) != '0);
        end
    end

    assign rd1      = r_pd[0][RD_LAT-1];
    assign rvalid1  = r_pv[0][RD_LAT-1];
    assign rd2      = r_pd[1][RD_LAT-1];
    assign rvalid2  = r_pv[1][RD_LAT-1];
    assign wcollide = r_wcollide;

endmodule

// File: tb/tb_v_sram_mp.sv
// Bench for v_sram_mp: two instances share one stimulus stream.
// A: DEPTH=8, RD_LAT=3, BYPASS=1.  B: DEPTH=6, RD_LAT=2, BYPASS=0.
// Expected reads are queued at issue time and matched against rvalid/rd each cycle.
module tb_v_sram_mp;

    logic        clock;
    logic        reset;
    logic        we1, we2, re1, re2;
    logic [2:0]  wa1, wa2, ra1, ra2;
    logic [63:0] wd1, wd2;
    logic [7:0]  wbe1, wbe2;

    logic        busyo [0:1];
    logic        wco   [0:1];
    logic        rvo   [0:1][0:1];
    logic [63:0] rdo   [0:1][0:1];

    v_sram_mp #(.DATA_W(64), .DEPTH(8), .ADDR_W(3), .RD_LAT(3), .BYPASS(1)) u_a (
        .clock(clock), .reset(reset), .init_busy(busyo[0]),
        .we1(we1), .wa1(wa1), .wd1(wd1), .wbe1(wbe1),
        .we2(we2), .wa2(wa2), .wd2(wd2), .wbe2(wbe2),
        .re1(re1), .ra1(ra1), .rd1(rdo[0][0]), .rvalid1(rvo[0][0]),
        .re2(re2), .ra2(ra2), .rd2(rdo[0][1]), .rvalid2(rvo[0][1]),
        .wcollide(wco[0])
    );

    v_sram_mp #(.DATA_W(64), .DEPTH(6), .ADDR_W(3), .RD_LAT(2), .BYPASS(0)) u_b (
        .clock(clock), .reset(reset), .init_busy(busyo[1]),
        .we1(we1), .wa1(wa1), .wd1(wd1), .wbe1(wbe1),
        .we2(we2), .wa2(wa2), .wd2(wd2), .wbe2(wbe2),
        .re1(re1), .ra1(ra1), .rd1(rdo[1][0]), .rvalid1(rvo[1][0]),
        .re2(re2), .ra2(ra2), .rd2(rdo[1][1]), .rvalid2(rvo[1][1]),
        .wcollide(wco[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int          d;
        int          p;
        int          cyc;
        logic [63:0] dat;
    } exp_t;

    exp_t        q[$];
    logic [63:0] mm     [0:1][0:7];
    logic [63:0] last_m [0:1][0:1];
    int          busy_m [0:1];
    logic        exp_wc [0:1];
    int          cycle;
    int          n_checks;
    int          n_fail;
    bit          started;

    function automatic int dep(input int d);
        return (d == 0) ? 8 : 6;
    endfunction
    function automatic int lat(input int d);
        return (d == 0) ? 3 : 2;
    endfunction
    function automatic bit byp(input int d);
        return (d == 0);
    endfunction

    // Post-write view of address a: port 1 bytes first, port 2 bytes over them.
    function automatic logic [63:0] overlay(input logic [63:0] base, input logic [2:0] a, input int dp);
        logic [63:0] v;
        v = base;
        if (we1 && wa1 == a && int'(wa1) < dp)
            for (int b = 0; b < 8; b++) if (wbe1[b]) v[b*8 +: 8] = wd1[b*8 +: 8];
        if (we2 && wa2 == a && int'(wa2) < dp)
            for (int b = 0; b < 8; b++) if (wbe2[b]) v[b*8 +: 8] = wd2[b*8 +: 8];
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        we1 = 0; we2 = 0; re1 = 0; re2 = 0;
        wbe1 = 8'hFF; wbe2 = 8'hFF;
    endtask

    task automatic step();
        logic [63:0] v;
        logic [63:0] t;
        logic [2:0]  a;
        bit          rdy;
        bit          found;
        string       nm;
        for (int d = 0; d < 2; d++) begin
            rdy = started && !reset && (busy_m[d] == 0);
            exp_wc[d] = rdy && we1 && we2 && (wa1 == wa2) && ((wbe1 & wbe2) != 8'h00);
            if (rdy) begin
                for (int p = 0; p < 2; p++) begin
                    if ((p == 0) ? re1 : re2) begin
                        a = (p == 0) ? ra1 : ra2;
                        v = (int'(a) < dep(d)) ? mm[d][a] : 64'h0;
                        if (byp(d)) v = overlay(v, a, dep(d));
                        q.push_back('{d, p, cycle + lat(d), v});
                    end
                end
                if (we1 && int'(wa1) < dep(d)) begin
                    t = mm[d][wa1];
                    for (int b = 0; b < 8; b++) if (wbe1[b]) t[b*8 +: 8] = wd1[b*8 +: 8];
                    mm[d][wa1] = t;
                end
                if (we2 && int'(wa2) < dep(d)) begin
                    t = mm[d][wa2];
                    for (int b = 0; b < 8; b++) if (wbe2[b]) t[b*8 +: 8] = wd2[b*8 +: 8];
                    mm[d][wa2] = t;
                end
            end
        end
        @(posedge clock);
        #1;
        cycle++;
        if (reset) begin
            started = 1;
            q.delete();
            for (int d = 0; d < 2; d++) begin
                busy_m[d] = dep(d);
                for (int i = 0; i < 8; i++) mm[d][i] = 64'h0;
                last_m[d][0] = 64'h0;
                last_m[d][1] = 64'h0;
            end
        end else begin
            for (int d = 0; d < 2; d++) if (busy_m[d] > 0) busy_m[d]--;
        end
        if (started) begin
            for (int d = 0; d < 2; d++) begin
                nm = (d == 0) ? "A" : "B";
                chk($sformatf("%s.init_busy@%0d", nm, cycle), {63'h0, busyo[d]}, {63'h0, busy_m[d] > 0});
                chk($sformatf("%s.wcollide@%0d", nm, cycle), {63'h0, wco[d]}, {63'h0, exp_wc[d]});
                for (int p = 0; p < 2; p++) begin
                    found = 0;
                    v = 64'h0;
                    for (int i = 0; i < q.size(); i++) begin
                        if (q[i].d == d && q[i].p == p && q[i].cyc == cycle) begin
                            found = 1;
                            v = q[i].dat;
                            q.delete(i);
                            break;
                        end
                    end
                    chk($sformatf("%s.rvalid%0d@%0d", nm, p + 1, cycle), {63'h0, rvo[d][p]}, {63'h0, found});
                    chk($sformatf("%s.rd%0d@%0d", nm, p + 1, cycle), rdo[d][p], found ? v : last_m[d][p]);
                    if (found) last_m[d][p] = v;
                end
            end
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Counts edges until each instance drops init_busy (bounded). Requests issued
    // on the third edge must be ignored by both instances.
    task automatic wait_clear(output int na, output int nb);
        na = 0;
        nb = 0;
        for (int n = 1; n <= 20; n++) begin
            if (n == 3) begin
                we1 = 1; wa1 = 3'd1; wd1 = '1; wbe1 = 8'hFF;
                we2 = 1; wa2 = 3'd2; wd2 = '1; wbe2 = 8'hFF;
                re1 = 1; ra1 = 3'd1; re2 = 1; ra2 = 3'd2;
            end
            step();
            idle();
            if (na == 0 && busyo[0] === 1'b0) na = n;
            if (nb == 0 && busyo[1] === 1'b0) nb = n;
            if (na != 0 && nb != 0) break;
        end
    endtask

    initial begin
        int na, nb;
        n_checks = 0; n_fail = 0; cycle = 0; started = 0;
        for (int d = 0; d < 2; d++) begin
            busy_m[d] = 0; exp_wc[d] = 0;
            last_m[d][0] = 0; last_m[d][1] = 0;
            for (int i = 0; i < 8; i++) mm[d][i] = 0;
        end
        wa1 = 0; wa2 = 0; ra1 = 0; ra2 = 0; wd1 = 0; wd2 = 0;
        idle();
        reset = 1;

        // 1. Clear sequencer: reset state, clear length, array reads zero.
        steps(2);
        chk("rst_rd1_A", rdo[0][0], 64'h0);
        chk("rst_busy_B", {63'h0, busyo[1]}, 64'h1);
        reset = 0;
        wait_clear(na, nb);
        chk("clear_len_A", na, 8);
        chk("clear_len_B", nb, 6);
        for (int i = 0; i < 8; i++) begin
            re1 = 1; ra1 = 3'(i); re2 = 1; ra2 = 3'(7 - i);
            step();
        end
        idle();
        steps(4);
        // Reset at ptr=5 restarts the count.
        reset = 1; step(); reset = 0;
        steps(5);
        reset = 1; step(); reset = 0;
        wait_clear(na, nb);
        chk("reclear_len_A", na, 8);
        chk("reclear_len_B", nb, 6);

        // 2. Latency and back-to-back reads.
        we1 = 1; wa1 = 3'd4; wd1 = {8{8'hA5}};
        we2 = 1; wa2 = 3'd5; wd2 = {8{8'h3C}};
        step(); idle();
        re1 = 1; ra1 = 3'd4; step();
        ra1 = 3'd5; step();
        idle(); steps(5);
        chk("hold_rd1_A", rdo[0][0], {8{8'h3C}});
        chk("hold_rd1_B", rdo[1][0], {8{8'h3C}});

        // 3. Byte-enabled collision on address 7.
        we1 = 1; wa1 = 3'd7; wd1 = 64'h0; step(); idle();
        we1 = 1; wa1 = 3'd7; wd1 = {8{8'h11}}; wbe1 = 8'hFF;
        we2 = 1; wa2 = 3'd7; wd2 = {8{8'h22}}; wbe2 = 8'h0F;
        step(); idle();
        chk("wc_pulse_A", {63'h0, wco[0]}, 64'h1);
        re2 = 1; ra2 = 3'd7; step(); idle();
        chk("wc_once_A", {63'h0, wco[0]}, 64'h0);
        steps(4);
        chk("collide_A", rdo[0][1], 64'h1111_1111_2222_2222);
        we1 = 1; wa1 = 3'd7; wd1 = {8{8'h11}}; wbe1 = 8'hFF;
        we2 = 1; wa2 = 3'd7; wd2 = {8{8'h22}}; wbe2 = 8'h00;
        step(); idle();
        chk("wc_none_A", {63'h0, wco[0]}, 64'h0);
        re2 = 1; ra2 = 3'd7; step(); idle(); steps(4);
        chk("nocollide_A", rdo[0][1], {8{8'h11}});

        // 4. Read-during-write on address 2, then a write inside the read latency.
        we1 = 1; wa1 = 3'd2; wd1 = '1; step(); idle();
        we1 = 1; wa1 = 3'd2; wd1 = 64'h1; re2 = 1; ra2 = 3'd2; step(); idle();
        steps(4);
        chk("bypass_A", rdo[0][1], 64'h1);
        chk("nobypass_B", rdo[1][1], 64'hFFFF_FFFF_FFFF_FFFF);
        re1 = 1; ra1 = 3'd2; step(); idle();
        we2 = 1; wa2 = 3'd2; wd2 = 64'h55; step(); idle();
        steps(4);
        chk("inflight_A", rdo[0][0], 64'h1);

        // 5. Out-of-range accesses (B has DEPTH=6).
        we1 = 1; wa1 = 3'd7; wd1 = {8{8'h77}}; step(); idle();
        for (int i = 0; i < 8; i++) begin
            re1 = 1; ra1 = 3'(i); re2 = 1; ra2 = 3'(i); step();
        end
        idle(); steps(4);
        chk("oor_read7_A", rdo[0][0], {8{8'h77}});
        chk("oor_read7_B", rdo[1][0], 64'h0);

        // Mixed random traffic against the model.
        for (int i = 0; i < 40; i++) begin
            we1 = 1'($urandom_range(0, 1)); wa1 = 3'($urandom_range(0, 7));
            wd1 = {$urandom, $urandom};     wbe1 = 8'($urandom_range(0, 255));
            we2 = 1'($urandom_range(0, 1)); wa2 = 3'($urandom_range(0, 7));
            wd2 = {$urandom, $urandom};     wbe2 = 8'($urandom_range(0, 255));
            re1 = 1'($urandom_range(0, 1)); ra1 = 3'($urandom_range(0, 7));
            re2 = 1'($urandom_range(0, 1)); ra2 = 3'($urandom_range(0, 7));
            step();
        end
        idle(); steps(5);

        // 6. Reset one cycle after a read request.
        re1 = 1; ra1 = 3'd4; step(); idle();
        reset = 1; step(); reset = 0;
        steps(2);
        chk("rstread_rd1_A", rdo[0][0], 64'h0);
        chk("rstread_rd1_B", rdo[1][0], 64'h0);
        chk("rstread_busy_A", {63'h0, busyo[0]}, 64'h1);
        chk("rstread_busy_B", {63'h0, busyo[1]}, 64'h1);
        // Two INIT edges have already passed since reset released.
        wait_clear(na, nb);
        chk("rstread_clear_A", na, 6);
        chk("rstread_clear_B", nb, 4);
        steps(2);
        chk("sb_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
